id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pkg.sv | 20 ++
 rtl/id_ex_if.sv | 65 ++++++
 rtl/id_ex_hazard.sv | 29 ++
 rtl/id_ex_pipe.sv | 126 ++++++++++++
 tb/tb_id_ex_pipe.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared widths and constants for the ID/EX pipeline register slice.
// Control-group layout (WB / M / EX) and default datapath geometry live here so
// the interface, the hazard unit and the pipeline register agree on them.
package id_ex_pkg;

    // Control-group widths carried from decode into execute.
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 5;

    // Position of MemRead inside the M control group.
    localparam int MEMREAD_BIT = 1;

    // Default geometry: 32-bit datapath, 32 architectural registers,
    // 16-bit bubble counter.
    localparam int DEF_DW = 32;
    localparam int DEF_RW = 5;
    localparam int DEF_CW = 16;

endpackage

// File: rtl/id_ex_if.sv
// id_ex_if: decode-side payload, execute-side registered copy and the
// stall/flush sideband of the ID/EX stage, bundled as one bus.
// The slave modport is the pipeline register; the master modport is the
// surrounding core (decode stage, hazard sources, execute consumers).
interface id_ex_if
    import id_ex_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW,
    parameter int CW = DEF_CW
);

    // Decode-stage payload
    logic            id_valid;
    logic [DW-1:0]   id_pc4;
    logic [DW-1:0]   id_rd1;
    logic [DW-1:0]   id_rd2;
    logic [DW-1:0]   id_imm;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic [RW-1:0]   id_rd;
    logic [WB_W-1:0] id_wb;
    logic [M_W-1:0]  id_m;
    logic [EX_W-1:0] id_ex;

    // Pipeline control sideband
    logic            ex_stall;
    logic            flush;

    // Execute-stage registered copy
    logic            ex_valid;
    logic [DW-1:0]   ex_pc4;
    logic [DW-1:0]   ex_rd1;
    logic [DW-1:0]   ex_rd2;
    logic [DW-1:0]   ex_imm;
    logic [RW-1:0]   ex_rs;
    logic [RW-1:0]   ex_rt;
    logic [RW-1:0]   ex_rd;
    logic [WB_W-1:0] ex_wb;
    logic [M_W-1:0]  ex_m;
    logic [EX_W-1:0] ex_ex;

    // Upstream freeze and bubble statistics
    logic            stall_up;
    logic [CW-1:0]   bubble_cnt;

    modport master (
        output id_valid, id_pc4, id_rd1, id_rd2, id_imm,
        output id_rs, id_rt, id_rd, id_wb, id_m, id_ex,
        output ex_stall, flush,
        input  ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm,
        input  ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ex,
        input  stall_up, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc4, id_rd1, id_rd2, id_imm,
        input  id_rs, id_rt, id_rd, id_wb, id_m, id_ex,
        input  ex_stall, flush,
        output ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm,
        output ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ex,
        output stall_up, bubble_cnt
    );

endinterface

// File: rtl/id_ex_hazard.sv
// id_ex_hazard: combinational load-use detector.
// Flags a hazard when a valid load sits in EX and the valid instruction in ID
// reads the register that load is about to write. Register 0 is hardwired to
// zero, so a load targeting it never creates a dependency.
module id_ex_hazard
    import id_ex_pkg::*;
#(
    parameter int RW = DEF_RW
) (
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          hazard
);

    logic rt_nonzero;
    logic src_match;

    // Dependency check against the load destination in EX.
    always_comb begin
        rt_nonzero = (ex_rt != '0);
        src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
        hazard     = ex_valid && ex_memread && rt_nonzero && id_valid && src_match;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion.
// Update priority: reset, downstream hold (ex_stall), flush, load-use hazard,
// normal load. Flush and hazard both load a bubble: valid and all control
// groups cleared while the data fields still take the decode values so the
// register contents stay deterministic.
// Optional build macro ID_EX_BUBBLE_CNT_EN adds a saturating count of loaded
// bubbles on bubble_cnt; without it bubble_cnt is tied to zero and no counter
// flops exist.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW,
    parameter int CW = DEF_CW
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);

    // EX-stage state
    logic            vld_p1;
    logic [DW-1:0]   pc4_p1;
    logic [DW-1:0]   rd1_p1;
    logic [DW-1:0]   rd2_p1;
    logic [DW-1:0]   imm_p1;
    logic [RW-1:0]   rs_p1;
    logic [RW-1:0]   rt_p1;
    logic [RW-1:0]   rd_p1;
    logic [WB_W-1:0] wb_p1;
    logic [M_W-1:0]  m_p1;
    logic [EX_W-1:0] ex_p1;

    logic hazard;
    logic bubble;

    id_ex_hazard #(
        .RW (RW)
    ) u_hazard (
        .ex_valid   (vld_p1),
        .ex_memread (m_p1[MEMREAD_BIT]),
        .ex_rt      (rt_p1),
        .id_valid   (bus.id_valid),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .hazard     (hazard)
    );

    // A flush already kills the dependent instruction, so it must not also
    // freeze the front end; otherwise the killed instruction would reappear.
    always_comb begin
        bubble       = bus.flush || hazard;
        bus.stall_up = bus.ex_stall || (hazard && !bus.flush);
    end

    // ID -> EX stage boundary: hold, bubble or load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            pc4_p1 <= '0;
            rd1_p1 <= '0;
            rd2_p1 <= '0;
            imm_p1 <= '0;
            rs_p1  <= '0;
            rt_p1  <= '0;
            rd_p1  <= '0;
            wb_p1  <= '0;
            m_p1   <= '0;
            ex_p1  <= '0;
        end else if (!bus.ex_stall) begin
            pc4_p1 <= bus.id_pc4;
            rd1_p1 <= bus.id_rd1;
            rd2_p1 <= bus.id_rd2;
            imm_p1 <= bus.id_imm;
            rs_p1  <= bus.id_rs;
            rt_p1  <= bus.id_rt;
            rd_p1  <= bus.id_rd;
            if (bubble) begin
                vld_p1 <= 1'b0;
                wb_p1  <= '0;
                m_p1   <= '0;
                ex_p1  <= '0;
            end else begin
                vld_p1 <= bus.id_valid;
                wb_p1  <= bus.id_wb;
                m_p1   <= bus.id_m;
                ex_p1  <= bus.id_ex;
            end
        end
    end

    assign bus.ex_valid = vld_p1;
    assign bus.ex_pc4   = pc4_p1;
    assign bus.ex_rd1   = rd1_p1;
    assign bus.ex_rd2   = rd2_p1;
    assign bus.ex_imm   = imm_p1;
    assign bus.ex_rs    = rs_p1;
    assign bus.ex_rt    = rt_p1;
    assign bus.ex_rd    = rd_p1;
    assign bus.ex_wb    = wb_p1;
    assign bus.ex_m     = m_p1;
    assign bus.ex_ex    = ex_p1;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CW-1:0] bcnt_p1;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Count every cycle in which a bubble is actually loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_p1 <= '0;
        end else if (!bus.ex_stall && bubble) begin
            bcnt_p1 <= sat_inc(bcnt_p1);
        end
    end

    assign bus.bubble_cnt = bcnt_p1;
`else
    assign bus.bubble_cnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed bench for id_ex_pipe with a 2-bit bubble counter.
// Expected bubble counts depend on whether ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_pipe;
    import id_ex_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    int nvec = 0;
    int nerr = 0;

    id_ex_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

    id_ex_pipe #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bc(input int n);
        return BC ? 64'(n) : 64'd0;
    endfunction

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [DW-1:0] pc4, input logic [DW-1:0] rd1,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [WB_W-1:0] wb, input logic [M_W-1:0] m,
                          input logic [EX_W-1:0] ex);
        bus.id_valid = v;
        bus.id_pc4   = pc4;
        bus.id_rd1   = rd1;
        bus.id_rd2   = ~rd1;
        bus.id_imm   = pc4 + 32'h100;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = 5'd3;
        bus.id_wb    = wb;
        bus.id_m     = m;
        bus.id_ex    = ex;
    endtask

    initial begin
        logic [63:0] sat_exp [5];
        sat_exp[0] = 64'd1; sat_exp[1] = 64'd2; sat_exp[2] = 64'd3;
        sat_exp[3] = 64'd3; sat_exp[4] = 64'd3;

        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        set_id(1'b1, 32'h77, 32'h1234, 5'd4, 5'd6, 2'b11, 3'b010, 5'h1f);

        // Asynchronous reset before any clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.ex_valid, 0);
        chk("rst_async_pc4", bus.ex_pc4, 0);
        chk("rst_async_rd1", bus.ex_rd1, 0);
        chk("rst_async_wb", bus.ex_wb, 0);
        chk("rst_async_m", bus.ex_m, 0);
        chk("rst_async_bcnt", bus.bubble_cnt, 0);
        chk("rst_async_stall_up", bus.stall_up, 0);

        // Clock edge while in reset keeps everything cleared
        tick();
        chk("rst_edge_valid", bus.ex_valid, 0);
        chk("rst_edge_ex", bus.ex_ex, 0);

        // Release reset; first instruction loads on the next edge
        rst = 1'b0;
        set_id(1'b1, 32'h10, 32'hA5A5A5A5, 5'd0, 5'd0, 2'b11, 3'b000, 5'h00);
        tick();
        chk("load_pc4", bus.ex_pc4, 32'h10);
        chk("load_rd1", bus.ex_rd1, 32'hA5A5A5A5);
        chk("load_rd2", bus.ex_rd2, 32'h5A5A5A5A);
        chk("load_imm", bus.ex_imm, 32'h110);
        chk("load_wb", bus.ex_wb, 2'b11);
        chk("load_valid", bus.ex_valid, 1);

        // Load-use: lw r8 into EX, dependent instruction reading rs=8
        set_id(1'b1, 32'h20, 32'h0, 5'd1, 5'd8, 2'b11, 3'b010, 5'h03);
        tick();
        chk("lw_m", bus.ex_m, 3'b010);
        chk("lw_rt", bus.ex_rt, 8);
        set_id(1'b1, 32'h24, 32'h1111, 5'd8, 5'd2, 2'b10, 3'b000, 5'h11);
        #1;
        chk("lu_stall_up", bus.stall_up, 1);
        tick();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_wb", bus.ex_wb, 0);
        chk("lu_bubble_m", bus.ex_m, 0);
        chk("lu_bubble_ex", bus.ex_ex, 0);
        chk("lu_bubble_pc4", bus.ex_pc4, 32'h24);
        chk("lu_bcnt", bus.bubble_cnt, bc(1));
        chk("lu_stall_up_cleared", bus.stall_up, 0);
        tick();
        chk("lu_reload_valid", bus.ex_valid, 1);
        chk("lu_reload_pc4", bus.ex_pc4, 32'h24);
        chk("lu_reload_wb", bus.ex_wb, 2'b10);
        chk("lu_reload_ex", bus.ex_ex, 5'h11);
        chk("lu_reload_rs", bus.ex_rs, 8);

        // Load into r0 never stalls
        set_id(1'b1, 32'h30, 32'h0, 5'd0, 5'd0, 2'b11, 3'b010, 5'h00);
        tick();
        set_id(1'b1, 32'h34, 32'h2222, 5'd0, 5'd0, 2'b01, 3'b000, 5'h02);
        #1;
        chk("r0_stall_up", bus.stall_up, 0);
        tick();
        chk("r0_valid", bus.ex_valid, 1);
        chk("r0_pc4", bus.ex_pc4, 32'h34);
        chk("r0_wb", bus.ex_wb, 2'b01);
        chk("r0_bcnt", bus.bubble_cnt, bc(1));

        // Flush together with a load-use hazard (match on rt)
        set_id(1'b1, 32'h40, 32'h0, 5'd0, 5'd8, 2'b11, 3'b010, 5'h00);
        tick();
        set_id(1'b1, 32'h44, 32'h3333, 5'd3, 5'd8, 2'b11, 3'b000, 5'h04);
        bus.flush = 1'b1;
        #1;
        chk("fh_stall_up", bus.stall_up, 0);
        tick();
        bus.flush = 1'b0;
        chk("fh_valid", bus.ex_valid, 0);
        chk("fh_wb", bus.ex_wb, 0);
        chk("fh_pc4", bus.ex_pc4, 32'h44);
        chk("fh_bcnt", bus.bubble_cnt, bc(2));

        // Hold: downstream stall beats flush for 3 cycles
        set_id(1'b1, 32'h50, 32'hDEADBEEF, 5'd2, 5'd9, 2'b10, 3'b001, 5'h07);
        tick();
        chk("hold_pre_pc4", bus.ex_pc4, 32'h50);
        bus.ex_stall = 1'b1;
        bus.flush    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h60 + i, i, 5'd1, 5'd1, 2'b01, 3'b010, 5'h1f);
            #1;
            chk("hold_stall_up", bus.stall_up, 1);
            tick();
            chk("hold_pc4", bus.ex_pc4, 32'h50);
            chk("hold_rd1", bus.ex_rd1, 32'hDEADBEEF);
            chk("hold_ctl", {bus.ex_valid, bus.ex_wb, bus.ex_m, bus.ex_ex},
                {1'b1, 2'b10, 3'b001, 5'h07});
            chk("hold_bcnt", bus.bubble_cnt, bc(2));
        end

        // Reset in the middle of a stall discards held contents
        bus.flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", bus.ex_valid, 0);
        chk("rstmid_pc4", bus.ex_pc4, 0);
        chk("rstmid_bcnt", bus.bubble_cnt, 0);
        chk("rstmid_stall_up_hi", bus.stall_up, 1);
        bus.ex_stall = 1'b0;
        #1;
        chk("rstmid_stall_up_lo", bus.stall_up, 0);
        rst = 1'b0;

        // Consecutive flushes saturate the 2-bit counter
        set_id(1'b1, 32'h80, 32'h0, 5'd0, 5'd0, 2'b11, 3'b111, 5'h1f);
        bus.flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_valid", bus.ex_valid, 0);
            chk("sat_bcnt", bus.bubble_cnt, BC ? sat_exp[i] : 64'd0);
        end
        bus.flush = 1'b0;
        tick();
        chk("post_sat_valid", bus.ex_valid, 1);
        chk("post_sat_m", bus.ex_m, 3'b111);
        chk("post_sat_bcnt", bus.bubble_cnt, bc(3));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Absolute watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
